// File: rtl/data_ram_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_resp_pkg
// Purpose  : Shared constants, FSM state encoding and a lane-mask helper for
//            the MEM-stage data-memory responder.
// Contents :
//   CHIP_ENABLE, WRITE_ENABLE - active levels of ce_i / we_i
//   ZERO_WORD                 - all-zero 32-bit bus value
//   DATA_MEM_NUM_LOG2         - default word-index width of the data SRAM
//   dram_state_t              - DRAM_IDLE / DRAM_WAIT / DRAM_RESP
//   lane_mask()               - expands 4 byte selects into a 32-bit mask
// Revision : 1.0 - initial release
// ============================================================================
package data_ram_resp_pkg;

    localparam logic        CHIP_ENABLE       = 1'b1;
    localparam logic        WRITE_ENABLE      = 1'b1;
    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
    localparam int          DATA_MEM_NUM_LOG2 = 10;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'd0,
        DRAM_WAIT = 2'd1,
        DRAM_RESP = 2'd2
    } dram_state_t;

    // sel[3] covers data[31:24] (byte offset 0) down to sel[0] for data[7:0].
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage : data_ram_resp_pkg
`default_nettype wire

// File: rtl/data_ram_resp_sram.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_core
// Purpose  : 2**ADDR_WIDTH x 32 single-port SRAM with per-byte write enables
//            and a registered read port. The array carries no reset so that
//            synthesis maps it onto block RAM.
// Ports    :
//   clk   in  1           clock, rising edge
//   we    in  1           write strobe
//   be    in  4           byte write enables, be[k] -> wdata[8k+7:8k]
//   addr  in  ADDR_WIDTH  word index, shared by read and write
//   wdata in  32          write data
//   re    in  1           read strobe; rdata updates on the next edge
//   rdata out 32          registered read data
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_core #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule : data_sram_core
`default_nettype wire

// File: rtl/data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_resp
// Purpose  : Responder side of the MEM-stage data-memory interface. Stores
//            are byte-merged and committed in one cycle; loads take two
//            cycles and raise a stall request so MEM holds its inputs until
//            the read data is valid. Out-of-range accesses pulse addr_err_o.
// Ports    :
//   clk        in  1   clock, rising edge
//   rst        in  1   synchronous, active-high reset
//   ce_i       in  1   access request from MEM
//   we_i       in  1   1 = store, 0 = load
//   addr_i     in  32  byte address (bits [1:0] ignored)
//   sel_i      in  4   byte lanes, sel_i[3] = data[31:24]
//   data_i     in  32  lane-replicated store data
//   flush_i    in  1   abandon any in-flight load
//   data_o     out 32  masked load data
//   stallreq_o out 1   hold MEM-stage inputs stable
//   addr_err_o out 1   access outside the mapped range
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int          ADDR_WIDTH = DATA_MEM_NUM_LOG2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    input  logic        flush_i,
    output logic [31:0] data_o,
    output logic        stallreq_o,
    output logic        addr_err_o
);

    dram_state_t state;
    dram_state_t state_next;

    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  mem_we;
    logic                  mem_re;
    logic [31:0]           mem_rdata;

    // Range check: below BASE_ADDR wraps to a huge offset, so the single
    // upper-bits test is only trusted together with the explicit compare.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = (addr_i >= BASE_ADDR) &&
                      ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
    assign idx      = offset[ADDR_WIDTH+1:2];

    data_sram_core #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .be    (sel_i),
        .addr  (idx),
        .wdata (data_i),
        .re    (mem_re),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DRAM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        data_o     = ZERO_WORD;
        stallreq_o = 1'b0;
        addr_err_o = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        case (state)
            DRAM_IDLE: begin
                if (ce_i == CHIP_ENABLE && !flush_i) begin
                    if (!in_range) begin
                        addr_err_o = 1'b1;
                    end else if (we_i == WRITE_ENABLE) begin
                        // sel_i == 0 is MEM's misaligned encoding: no write.
                        mem_we = |sel_i;
                    end else begin
                        stallreq_o = 1'b1;
                        mem_re     = 1'b1;
                        state_next = DRAM_WAIT;
                    end
                end
            end

            DRAM_WAIT: begin
                if (flush_i) begin
                    state_next = DRAM_IDLE;
                end else begin
                    // MEM still presents the load, so sel_i is the load's lanes.
                    data_o     = mem_rdata & lane_mask(sel_i);
                    state_next = DRAM_RESP;
                end
            end

            DRAM_RESP: begin
                // Guard cycle: a request arriving here is held by stalling and
                // serviced once back in IDLE.
                stallreq_o = (ce_i == CHIP_ENABLE) && !flush_i;
                state_next = DRAM_IDLE;
            end

            default: begin
                state_next = DRAM_IDLE;
            end
        endcase

        if (rst) begin
            data_o     = ZERO_WORD;
            stallreq_o = 1'b0;
            addr_err_o = 1'b0;
            mem_we     = 1'b0;
            mem_re     = 1'b0;
        end
    end

endmodule : data_ram_resp
`default_nettype wire

// File: tb/tb_data_ram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_resp
// Purpose  : Self-checking bench for data_ram_resp: directed scenarios plus a
//            randomized mix checked against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_ram_resp;

    localparam int          AW    = 10;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic        flush_i;
    logic [31:0] data_o;
    logic        stallreq_o;
    logic        addr_err_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [int];

    data_ram_resp #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .sel_i      (sel_i),
        .data_i     (data_i),
        .flush_i    (flush_i),
        .data_o     (data_o),
        .stallreq_o (stallreq_o),
        .addr_err_o (addr_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic bit in_map(input logic [31:0] a);
        longint d;
        d = longint'(a) - longint'(BASE);
        return (d >= 0) && (d < 4 * longint'(DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    // Byte at address offset j lives in bits [31-8j -: 8] and is enabled by sel[3-j].
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int j = 0; j < 4; j++)
            if (s[3-j]) r[31-8*j -: 8] = d[31-8*j -: 8];
        return r;
    endfunction

    function automatic logic [31:0] expect_load(input logic [31:0] a, input logic [3:0] s);
        logic [31:0] w;
        logic [31:0] r;
        w = model[widx(a)];
        r = 32'h0;
        for (int j = 0; j < 4; j++)
            if (s[3-j]) r[31-8*j -: 8] = w[31-8*j -: 8];
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        ce_i = 0; we_i = 0; addr_i = 0; sel_i = 0; data_i = 0; flush_i = 0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, input string tag);
        ce_i = 1; we_i = 1; addr_i = a; sel_i = s; data_i = d; flush_i = 0;
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL %s store_stall: got %b expected 0", tag, stallreq_o);
        end
        checks++;
        if (addr_err_o !== (in_map(a) ? 1'b0 : 1'b1)) begin
            failures++;
            $display("FAIL %s store_err: got %b expected %b", tag, addr_err_o, !in_map(a));
        end
        tick();
        if (in_map(a) && (model.exists(widx(a)) || s == 4'hF))
            model[widx(a)] = merge(model.exists(widx(a)) ? model[widx(a)] : 32'h0, d, s);
        set_idle();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] exp, input string tag);
        ce_i = 1; we_i = 0; addr_i = a; sel_i = s; data_i = $urandom; flush_i = 0;
        #1;
        if (in_map(a)) begin
            checks++;
            if (stallreq_o !== 1'b1 || addr_err_o !== 1'b0) begin
                failures++;
                $display("FAIL %s load_issue: stall=%b err=%b expected stall=1 err=0",
                         tag, stallreq_o, addr_err_o);
            end
            tick();
            #1;
            checks++;
            if (data_o !== exp || stallreq_o !== 1'b0) begin
                failures++;
                $display("FAIL %s load_data: got %h stall=%b expected %h stall=0",
                         tag, data_o, stallreq_o, exp);
            end
            tick();
            set_idle();
            #1;
            checks++;
            if (data_o !== 32'h0 || stallreq_o !== 1'b0) begin
                failures++;
                $display("FAIL %s load_guard: data=%h stall=%b expected 0/0",
                         tag, data_o, stallreq_o);
            end
            tick();
        end else begin
            checks++;
            if (addr_err_o !== 1'b1 || stallreq_o !== 1'b0 || data_o !== 32'h0) begin
                failures++;
                $display("FAIL %s load_oor: err=%b stall=%b data=%h expected 1/0/0",
                         tag, addr_err_o, stallreq_o, data_o);
            end
            tick();
            set_idle();
            #1;
            checks++;
            if (addr_err_o !== 1'b0) begin
                failures++;
                $display("FAIL %s err_pulse_len: got %b expected 0", tag, addr_err_o);
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        ce_i = 1; we_i = 0; addr_i = 32'h10; sel_i = 4'hF; data_i = 0; flush_i = 0;
        tick();
        tick();
        #1;
        checks++;
        if (data_o !== 32'h0 || stallreq_o !== 1'b0 || addr_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_during: data=%h stall=%b err=%b expected 0/0/0",
                     data_o, stallreq_o, addr_err_o);
        end
        rst = 0;
        set_idle();
        #1;
        checks++;
        if (data_o !== 32'h0 || stallreq_o !== 1'b0 || addr_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_after: data=%h stall=%b err=%b expected 0/0/0",
                     data_o, stallreq_o, addr_err_o);
        end
        tick();
    endtask

    task automatic test_basic();
        do_store(32'h10, 4'hF, 32'hDEADBEEF, "basic");
        do_load(32'h10, 4'hF, 32'hDEADBEEF, "basic");
    endtask

    task automatic test_byte_lanes();
        do_store(32'h10, 4'b0100, 32'h5A5A5A5A, "byte");
        do_load(32'h10, 4'hF, 32'hDE5ABEEF, "byte");
        do_store(32'h10, 4'b0011, 32'h12341234, "half");
        do_load(32'h10, 4'b1100, 32'hDE5A0000, "half_hi");
        do_load(32'h10, 4'hF, 32'hDE5A1234, "half_full");
        do_store(32'h12, 4'b0000, 32'hFFFFFFFF, "sel0");
        do_load(32'h10, 4'hF, 32'hDE5A1234, "sel0_unchanged");
    endtask

    task automatic test_out_of_range();
        do_store(32'h0, 4'hF, 32'h0BADF00D, "oor_init");
        do_load(BASE + 4 * DEPTH, 4'hF, 32'h0, "oor_load");
        do_store(BASE + 4 * DEPTH, 4'hF, 32'hFFFFFFFF, "oor_store");
        do_store(32'hFFFF_FFFC, 4'hF, 32'hFFFFFFFF, "oor_store_top");
        do_load(32'h0, 4'hF, 32'h0BADF00D, "oor_addr0");
        do_store(BASE + 4 * DEPTH - 4, 4'hF, 32'hA5C3E1F0, "last_word");
        do_load(BASE + 4 * DEPTH - 4, 4'hF, 32'hA5C3E1F0, "last_word");
    endtask

    task automatic test_store_in_guard();
        ce_i = 1; we_i = 0; addr_i = 32'h10; sel_i = 4'hF; flush_i = 0;
        tick();
        #1;
        checks++;
        if (data_o !== 32'hDE5A1234) begin
            failures++;
            $display("FAIL guard_load: got %h expected DE5A1234", data_o);
        end
        tick();
        we_i = 1; data_i = 32'hCAFEF00D;
        #1;
        checks++;
        if (stallreq_o !== 1'b1 || data_o !== 32'h0) begin
            failures++;
            $display("FAIL guard_stall: stall=%b data=%h expected 1/0", stallreq_o, data_o);
        end
        tick();
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL guard_commit_stall: got %b expected 0", stallreq_o);
        end
        tick();
        model[widx(32'h10)] = 32'hCAFEF00D;
        set_idle();
        do_load(32'h10, 4'hF, 32'hCAFEF00D, "guard_readback");
    endtask

    task automatic test_back_to_back();
        logic [4:0] stall_hist;
        do_store(32'h20, 4'hF, 32'h11111111, "b2b_init");
        do_store(32'h24, 4'hF, 32'h22222222, "b2b_init");
        stall_hist = '0;
        ce_i = 1; we_i = 0; addr_i = 32'h20; sel_i = 4'hF;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) addr_i = 32'h24;
            #1;
            stall_hist[c] = stallreq_o;
            if (c == 1) begin
                checks++;
                if (data_o !== 32'h11111111) begin
                    failures++;
                    $display("FAIL b2b_first: got %h expected 11111111", data_o);
                end
            end
            if (c == 4) begin
                checks++;
                if (data_o !== 32'h22222222) begin
                    failures++;
                    $display("FAIL b2b_second: got %h expected 22222222", data_o);
                end
            end
            tick();
        end
        checks++;
        if (stall_hist !== 5'b01101) begin
            failures++;
            $display("FAIL b2b_stall_pattern: got %b expected 01101 (cycle0 at lsb)", stall_hist);
        end
        set_idle();
        tick();
    endtask

    task automatic test_flush();
        ce_i = 1; we_i = 0; addr_i = 32'h20; sel_i = 4'hF;
        tick();
        flush_i = 1;
        #1;
        checks++;
        if (data_o !== 32'h0 || stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_wait: data=%h stall=%b expected 0/0", data_o, stallreq_o);
        end
        tick();
        // Back in IDLE: a new load stalls once and returns data the next cycle.
        flush_i = 0; addr_i = 32'h24;
        #1;
        checks++;
        if (stallreq_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_issue: stall=%b expected 1", stallreq_o);
        end
        tick();
        #1;
        checks++;
        if (data_o !== 32'h22222222 || stallreq_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_data: data=%h stall=%b expected 22222222/0",
                     data_o, stallreq_o);
        end
        tick();
        set_idle();
        tick();
        // Store with flush in IDLE is suppressed.
        ce_i = 1; we_i = 1; addr_i = 32'h20; sel_i = 4'hF; data_i = 32'h0; flush_i = 1;
        #1;
        checks++;
        if (stallreq_o !== 1'b0 || addr_err_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_store: stall=%b err=%b expected 0/0", stallreq_o, addr_err_o);
        end
        tick();
        set_idle();
        do_load(32'h20, 4'hF, 32'h11111111, "flush_store_readback");
    endtask

    task automatic test_rst_mid_load();
        ce_i = 1; we_i = 0; addr_i = 32'h24; sel_i = 4'hF;
        tick();
        rst = 1;
        tick();
        rst = 0;
        set_idle();
        #1;
        checks++;
        if (data_o !== 32'h0 || stallreq_o !== 1'b0 || addr_err_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_load: data=%h stall=%b err=%b expected 0/0/0",
                     data_o, stallreq_o, addr_err_o);
        end
        tick();
        do_load(32'h24, 4'hF, 32'h22222222, "rst_readback");
        do_load(32'h10, 4'hF, 32'hCAFEF00D, "rst_readback");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        int          op;
        for (int i = 64; i < 80; i++)
            do_store(BASE + 4 * i, 4'hF, $urandom, "rnd_init");
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            a  = BASE + 4 * $urandom_range(64, 79) + $urandom_range(0, 3);
            s  = 4'($urandom);
            d  = $urandom;
            if (op >= 8)
                a = ($urandom_range(0, 1) == 0) ? BASE + 4 * DEPTH + 4 * $urandom_range(0, 255)
                                                : 32'hFFFF_0000 | 32'($urandom_range(0, 16'hFFFF));
            if (op <= 3 || op == 9)
                do_store(a, s, d, "rnd_store");
            else
                do_load(a, s, in_map(a) ? expect_load(a, s) : 32'h0, "rnd_load");
        end
    endtask

    initial begin
        rst = 1;
        set_idle();
        test_reset();
        test_basic();
        test_byte_lanes();
        test_out_of_range();
        test_store_in_guard();
        test_back_to_back();
        test_flush();
        test_rst_mid_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_data_ram_resp
`default_nettype wire

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
Responder side of the MEM-stage data-memory interface. Accepts chip-enable, write-enable, byte-address, byte-select and write data from the MEM stage, and backs them with an on-chip synchronous-read SRAM.
- Stores: byte-lane merged and committed in a single cycle.
- Loads: take two cycles; the block raises a stall request so the pipeline controller holds MEM until read data is valid.
- Sits between mem and the pipeline ctrl stall logic in the top-level core.

Parameters:
- ADDR_WIDTH, 10, word-index width; memory depth = 2**ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- ce_i  in  1  chip enable from MEM stage; 1 = access requested.
- we_i  in  1  write enable; 1 = store, 0 = load.
- addr_i  in  32  byte address; word-aligned, because MEM encodes byte position in sel_i.
- sel_i  in  4  byte lane enables, big-endian: sel_i[3]=data[31:24] (addr offset 0) … sel_i[0]=data[7:0] (offset 3).
- data_i  in  32  store data, already lane-replicated by MEM.
- flush_i  in  1  pipeline flush; abandons an in-flight load.
- data_o  out  32  load data returned to MEM.
- stallreq_o  out  1  1 = hold MEM-stage inputs stable.
- addr_err_o  out  1  single-cycle pulse: access outside the mapped range.

Behaviour:
- Word index: idx = (addr_i - BASE_ADDR) >> 2. In range iff addr_i >= BASE_ADDR and idx < 2**ADDR_WIDTH. addr_i[1:0] is ignored.
- FSM states: IDLE, RD_WAIT, RD_RESP. Reset state is IDLE.
- On rst: state=IDLE, data_o=0, stallreq_o=0, addr_err_o=0, no memory write. Memory contents are not cleared.
- IDLE, ce_i=1, we_i=1, in range: commit at this edge. For each lane k with sel_i[k]=1, mem[idx] lane k <= data_i lane k; other lanes unchanged. No stall, state stays IDLE.
- IDLE, store with sel_i=0 (MEM's misaligned encoding): no write, no error.
- IDLE, ce_i=1, we_i=0, in range: stallreq_o=1 combinationally in this cycle; SRAM read issued; next state RD_WAIT.
- RD_WAIT: SRAM output is valid after the edge; stallreq_o=0. data_o = registered word masked by sel_i: lanes with sel=0 read as 0, sel=4'b1111 returns the full word. Next state RD_RESP.
- RD_RESP: one-cycle guard. data_o=0, stallreq_o=0; next state IDLE. A new request is first seen in IDLE.
- Load latency: request in cycle N; stall in N; data in N+1, when the pipeline advances.
- Back-to-back loads: the second load stalls one cycle after the guard. Consecutive loads issue at most one every 3 cycles.
- Store immediately after a load: lands in RD_RESP and is ignored, so ctrl must hold it. To make this safe, stallreq_o=1 in RD_RESP when ce_i=1. The request is then processed in IDLE the following cycle.
- Out of range, any ce_i=1 access in IDLE:
  - no write; addr_err_o=1 for exactly one cycle;
  - a load returns data_o=0 without stalling; state stays IDLE.
- ce_i=0 in IDLE: data_o=0, stallreq_o=0.
- flush_i=1:
  - in any state: next state IDLE, stallreq_o=0 in the same cycle, data_o=0;
  - in IDLE with a store pending: the store is suppressed.
- rst asserted mid-load: next state IDLE, no data returned, memory untouched.
- Simultaneous rst and flush_i: rst dominates; the result is identical anyway.

Decomposition:
- define.v (shared): ChipEnable, WriteEnable, ZeroWord, RegBus, plus new constants DataMemNumLog2 and the state encodings DRamIdle/DRamWait/DRamResp.
- One sub-module, data_sram_core: 2**ADDR_WIDTH x 32 array, 4 byte-write enables, registered read port. It must infer block RAM with no reset on the array.
- data_ram_resp keeps the FSM, range check, lane mask and error pulse.

Test Plan:
- Reset, then store 32'hDEADBEEF, sel=4'b1111, addr 0x10; then load addr 0x10 sel 4'b1111 -> stallreq_o=1 for one cycle, next cycle data_o=32'hDEADBEEF.
- Store byte 32'h5A5A5A5A, sel=4'b0100, into word 0x10 holding DEADBEEF -> load full word returns 32'hDE5ABEEF.
- Store halfword 32'h12341234, sel=4'b0011, then load sel 4'b1100 -> data_o=32'hDE5A0000; load sel 4'b1111 -> 32'hDE5A1234.
- Load at BASE_ADDR + 4*2**ADDR_WIDTH -> addr_err_o pulses one cycle, no stall, data_o=0. Store to the same address -> addr_err_o pulse, memory unchanged (check addr 0).
- Load, then a store in the guard cycle -> stallreq_o=1 in RD_RESP; store commits next cycle; a readback confirms it. Two back-to-back loads -> 3-cycle issue spacing.
- Load with flush_i=1 in RD_WAIT -> data_o=0, stallreq_o=0, state IDLE. rst during RD_WAIT -> all outputs 0 next cycle, and prior memory contents remain intact on readback.
